// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//   Upstream feeder for a fixed-latency ALU. Commands {a, b, sel} arrive over a
//   valid/ready handshake and are buffered in a DEPTH-entry FIFO. Each cycle with
//   i_issue_en=1 and a non-empty FIFO, the head command is popped onto the
//   registered ALU inputs. A valid/tag pipe tracks every issued op through the
//   LAT-cycle ALU. When an op completes, its result is returned tagged with its
//   opcode, in issue order. Commands whose sel[3] is set are consumed but not
//   queued, and they raise a one-cycle error pulse.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_cmd_valid         command present
//   o_cmd_ready         FIFO can accept (registered count < DEPTH)
//   i_cmd_a, i_cmd_b    signed operands (DW bits)
//   i_cmd_sel           opcode; sel[3]=1 is illegal
//   i_issue_en          1 = may pop and issue this cycle
//   o_alu_a/b/sel       registered ALU operands and opcode
//   i_alu_y             ALU result (YW bits)
//   o_res_valid         one-cycle pulse per completed op
//   o_res_y, o_res_sel  registered result and its opcode
//   o_err_illegal       one-cycle pulse when an illegal command was dropped
//   o_busy              FIFO non-empty or an op is in flight
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int DW    = 4,
  parameter int YW    = 8,
  parameter int LAT   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [DW-1:0] i_cmd_a,
  input  logic [DW-1:0] i_cmd_b,
  input  logic [3:0]    i_cmd_sel,
  input  logic          i_issue_en,
  output logic [DW-1:0] o_alu_a,
  output logic [DW-1:0] o_alu_b,
  output logic [3:0]    o_alu_sel,
  input  logic [YW-1:0] i_alu_y,
  output logic          o_res_valid,
  output logic [YW-1:0] o_res_y,
  output logic [3:0]    o_res_sel,
  output logic          o_err_illegal,
  output logic          o_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem_a   [DEPTH];
  logic [DW-1:0] r_mem_b   [DEPTH];
  logic [3:0]    r_mem_sel [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [3:0]    r_alu_sel;
  logic [LAT:0]  r_vpipe;
  logic [3:0]    r_tpipe [LAT+1];
  logic          r_res_valid;
  logic [YW-1:0] r_res_y;
  logic [3:0]    r_res_sel;
  logic          r_err_illegal;

  logic w_xfer;
  logic w_push;
  logic w_pop;

  // Ready comes from the registered count only, so a pop cannot open a slot
  // for a push on the same edge when the FIFO is full.
  assign o_cmd_ready = (r_count < CW'(DEPTH));
  assign w_xfer      = i_cmd_valid & o_cmd_ready;
  assign w_push      = w_xfer & ~i_cmd_sel[3];
  // Pop also uses the registered count: a command pushed into an empty FIFO
  // is issued no earlier than the following edge.
  assign w_pop       = i_issue_en & (r_count != '0);

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_sel     = r_alu_sel;
  assign o_res_valid   = r_res_valid;
  assign o_res_y       = r_res_y;
  assign o_res_sel     = r_res_sel;
  assign o_err_illegal = r_err_illegal;
  assign o_busy        = (r_count != '0) | (|r_vpipe);

  // Next FIFO occupancy from push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i]   <= '0;
        r_mem_b[i]   <= '0;
        r_mem_sel[i] <= 4'd0;
      end
    end else begin
      if (w_push) begin
        r_mem_a[r_wr_ptr]   <= i_cmd_a;
        r_mem_b[r_wr_ptr]   <= i_cmd_b;
        r_mem_sel[r_wr_ptr] <= i_cmd_sel;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Issue stage and in-flight tracking. Reset clears the tracking pipe, so the
  // ALU output for discarded ops is never sampled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= 4'd0;
      r_vpipe   <= '0;
      for (int i = 0; i <= LAT; i++) begin
        r_tpipe[i] <= 4'd0;
      end
    end else begin
      if (w_pop) begin
        r_alu_a   <= r_mem_a[r_rd_ptr];
        r_alu_b   <= r_mem_b[r_rd_ptr];
        r_alu_sel <= r_mem_sel[r_rd_ptr];
      end
      r_vpipe    <= {r_vpipe[LAT-1:0], w_pop};
      r_tpipe[0] <= r_mem_sel[r_rd_ptr];
      for (int i = 1; i <= LAT; i++) begin
        r_tpipe[i] <= r_tpipe[i-1];
      end
    end
  end

  // Result capture and illegal-command pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_valid   <= 1'b0;
      r_res_y       <= '0;
      r_res_sel     <= 4'd0;
      r_err_illegal <= 1'b0;
    end else begin
      r_err_illegal <= w_xfer & i_cmd_sel[3];
      if (r_vpipe[LAT]) begin
        r_res_valid <= 1'b1;
        r_res_y     <= i_alu_y;
        r_res_sel   <= r_tpipe[LAT];
      end else begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'd0, cmd_b = 4'd0, cmd_sel = 4'd0;
  logic       issue_en = 1'b0;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_y;
  logic       res_valid;
  logic [7:0] res_y;
  logic [3:0] res_sel;
  logic       err_illegal;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .DW(4), .YW(8), .LAT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_sel(cmd_sel), .i_issue_en(issue_en),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel), .i_alu_y(alu_y),
    .o_res_valid(res_valid), .o_res_y(res_y), .o_res_sel(res_sel),
    .o_err_illegal(err_illegal), .o_busy(busy)
  );

  // Arithmetic meaning of each opcode for the stub ALU, sign-extended to 8 bits.
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
    int ia, ib, r;
    logic [31:0] rv;
    ia = int'($signed(a));
    ib = int'($signed(b));
    case (sel)
      4'd0:    r = ia + 1;
      4'd1:    r = ia - 1;
      4'd2:    r = ia;
      4'd3:    r = ib;
      4'd4:    r = -ia;
      4'd5:    r = ia * ib;
      4'd6:    r = ia + ib;
      4'd7:    r = ia - ib;
      default: r = 0;
    endcase
    rv = r;
    return rv[7:0];
  endfunction

  // Stub ALU without reset: input register, then output register.
  logic [3:0] alu_ra, alu_rb, alu_rs;
  always @(posedge clk) begin
    alu_ra <= alu_a;
    alu_rb <= alu_b;
    alu_rs <= alu_sel;
    alu_y  <= alu_ref(alu_ra, alu_rb, alu_rs);
  end

  // Reference model: queue of pending commands, list of in-flight results with due cycle.
  typedef struct { logic [3:0] a; logic [3:0] b; logic [3:0] sel; } cmd_t;
  typedef struct { int due; logic [7:0] y; logic [3:0] sel; } res_t;
  cmd_t q[$];
  res_t fl[$];
  logic       exp_err = 1'b0;
  logic [3:0] last_a = 4'd0, last_b = 4'd0, last_sel = 4'd0;
  logic [7:0] last_y = 8'd0;
  logic [3:0] last_rsel = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, then check outputs.
  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] sel, input logic ie);
    logic rdy, popv, expv;
    cmd_t head;
    res_t item;
    rst = r; cmd_valid = v; cmd_a = a; cmd_b = b; cmd_sel = sel; issue_en = ie;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete(); fl.delete(); exp_err = 1'b0;
      last_a = 4'd0; last_b = 4'd0; last_sel = 4'd0; last_y = 8'd0; last_rsel = 4'd0;
    end else begin
      rdy  = (q.size() < DEPTH);
      popv = ie && (q.size() > 0);
      exp_err = v && rdy && sel[3];
      if (popv) begin
        head = q.pop_front();
        last_a = head.a; last_b = head.b; last_sel = head.sel;
        item.due = cyc + 3;
        item.y   = alu_ref(head.a, head.b, head.sel);
        item.sel = head.sel;
        fl.push_back(item);
      end
      if (v && rdy && !sel[3]) begin
        head.a = a; head.b = b; head.sel = sel;
        q.push_back(head);
      end
    end
    #1;
    expv = (fl.size() > 0) && (fl[0].due == cyc);
    if (expv) begin
      last_y = fl[0].y; last_rsel = fl[0].sel;
      void'(fl.pop_front());
    end
    check_eq("res_valid", {31'd0, res_valid}, {31'd0, expv});
    check_eq("res_y", {24'd0, res_y}, {24'd0, last_y});
    check_eq("res_sel", {28'd0, res_sel}, {28'd0, last_rsel});
    check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, (q.size() < DEPTH)});
    check_eq("busy", {31'd0, busy}, {31'd0, (q.size() > 0) || (fl.size() > 0)});
    check_eq("err_illegal", {31'd0, err_illegal}, {31'd0, exp_err});
    check_eq("alu_a", {28'd0, alu_a}, {28'd0, last_a});
    check_eq("alu_b", {28'd0, alu_b}, {28'd0, last_b});
    check_eq("alu_sel", {28'd0, alu_sel}, {28'd0, last_sel});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
  endtask

  initial begin
    logic [3:0] ra, rb, rs;
    // T1: reset for two cycles
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(1);
    // T2: single op, result four edges after acceptance
    step(1'b0, 1'b1, 4'd3, 4'd2, 4'b0110, 1'b1);
    idle(6);
    // T3: back-to-back stream
    step(1'b0, 1'b1, 4'hD, 4'd2, 4'b0101, 1'b1);
    step(1'b0, 1'b1, 4'd2, 4'd5, 4'b0111, 1'b1);
    step(1'b0, 1'b1, 4'd7, 4'($urandom), 4'b0000, 1'b1);
    step(1'b0, 1'b1, 4'($urandom), 4'h8, 4'b0011, 1'b1);
    idle(6);
    // T4: fill with issue held, fifth command waits for a slot
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(i), 4'(i + 1), 4'b0110, 1'b0);
    step(1'b0, 1'b1, 4'd4, 4'd5, 4'b0110, 1'b1);
    step(1'b0, 1'b1, 4'd4, 4'd5, 4'b0110, 1'b1);
    idle(10);
    // T5: illegal opcode
    step(1'b0, 1'b1, 4'd1, 4'd1, 4'b1010, 1'b1);
    idle(5);
    // T6: reset with ops in flight
    step(1'b0, 1'b1, 4'd1, 4'd2, 4'b0110, 1'b1);
    step(1'b0, 1'b1, 4'd3, 4'd4, 4'b0101, 1'b1);
    step(1'b0, 1'b1, 4'd5, 4'd6, 4'b0111, 1'b1);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    idle(6);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), ra, rb, rs,
           ($urandom_range(0, 3) != 0));
    end
    idle(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
